// File: rtl/fifo_burst_reader.sv
// Drains a FIFO into bursts of up to MAX_BURST words.
// Each burst goes out as a count header followed by its data words.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rget,
    input  logic             flush,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_first,
    output logic             m_last,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(MAX_BURST);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HEADER,
        S_SEND
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [TW-1:0]    r_tmr;
    logic [WIDTH-1:0] r_buf [MAX_BURST];

    logic             w_take;
    logic             w_xfer;
    logic             w_last;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_take = (r_state == S_IDLE || r_state == S_COLLECT)
                  && !fifo_empty
                  && (r_cnt < CW'(MAX_BURST));
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_last = (r_state == S_SEND)
                  && (CW'(r_idx) == r_cnt - CW'(1));
    assign w_xfer = m_valid && m_ready;

    assign fifo_rget = w_take;
    assign m_valid   = (r_state == S_HEADER) || (r_state == S_SEND);
    assign m_first   = (r_state == S_HEADER);
    assign m_last    = w_last;
    assign busy      = (r_state != S_IDLE);
    assign m_data    = (r_state == S_HEADER) ? WIDTH'(r_cnt)
                                             : r_buf[r_idx];

    always_ff @(posedge rclk) begin
        if (w_take) begin
            r_buf[r_cnt[IW-1:0]] <= fifo_dout;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tmr   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_cnt   <= CW'(1);
                        r_tmr   <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // A word taken alongside flush still joins this burst
                    if (w_take) begin
                        r_cnt <= w_cnt_nxt;
                        r_tmr <= '0;
                        if (w_cnt_nxt == CW'(MAX_BURST) || flush) begin
                            r_state <= S_HEADER;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                        if (r_tmr == TW'(TIMEOUT - 1) || flush) begin
                            r_state <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_tmr   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: packet-level reference model
// plus directed bursts, timeout, flush, reset and random backpressure.
module tb_fifo_burst_reader;

    localparam int W  = 8;
    localparam int MB = 16;
    localparam int TO = 64;

    typedef struct packed {
        logic         f;
        logic         l;
        logic [W-1:0] d;
    } ent_t;

    logic         rclk = 1'b0;
    logic         rrst;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_rget;
    logic         flush;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_first;
    logic         m_last;
    logic         busy;

    fifo_burst_reader #(
        .WIDTH    (W),
        .MAX_BURST(MB),
        .TIMEOUT  (TO)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rget (fifo_rget),
        .flush     (flush),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_first   (m_first),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    logic [W-1:0] fq[$];
    logic [W-1:0] col[$];
    ent_t         outq[$];
    ent_t         dlog[$];
    int           idle_cnt = 0;
    logic         gate = 1'b1;
    int           cyc = 0;
    int           last_take = -1;
    int           hdr_cyc = -1;
    int           n_pass = 0;
    int           n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic bit model_idle();
        return fq.size() == 0 && col.size() == 0 && outq.size() == 0;
    endfunction

    // One clock: drive FIFO, compare, advance model, land on negedge.
    task automatic step();
        logic         e_rget;
        logic         close;
        logic [W-1:0] w;
        fifo_empty = (fq.size() == 0) || gate;
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
        #1;
        cyc++;
        e_rget = (outq.size() == 0) && !fifo_empty && (col.size() < MB);
        chk("rget", fifo_rget, e_rget);
        chk("valid", m_valid, outq.size() != 0);
        chk("busy", busy, (col.size() != 0) || (outq.size() != 0));
        if (outq.size() != 0) begin
            chk("data", m_data, outq[0].d);
            chk("first", m_first, outq[0].f);
            chk("last", m_last, outq[0].l);
        end
        if (fifo_rget) last_take = cyc;
        if (m_valid && m_first && hdr_cyc < 0) hdr_cyc = cyc;
        if (m_valid && m_ready) dlog.push_back({m_first, m_last, m_data});
        w = '0;
        close = 1'b0;
        if (e_rget) w = fq.pop_front();
        if (rrst) begin
            col.delete();
            outq.delete();
            idle_cnt = 0;
        end else if (outq.size() != 0) begin
            if (m_ready) void'(outq.pop_front());
        end else if (col.size() == 0) begin
            if (e_rget) begin
                col.push_back(w);
                idle_cnt = 0;
            end
        end else begin
            if (e_rget) begin
                col.push_back(w);
                idle_cnt = 0;
                close = (col.size() == MB) || flush;
            end else begin
                idle_cnt++;
                close = (idle_cnt == TO) || flush;
            end
            if (close) begin
                outq.push_back({1'b0 ^ 1'b1, 1'b0, W'(col.size())});
                for (int i = 0; i < col.size(); i++)
                    outq.push_back({1'b0, i == col.size() - 1, col[i]});
                col.delete();
                idle_cnt = 0;
            end
        end
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (!model_idle() && n < maxc) begin
            step();
            n++;
        end
        chk("drain_done", model_idle(), 1'b1);
    endtask

    initial begin
        int ndata;
        rrst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst = 1'b0;
        gate = 1'b0;
        #1;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rget", fifo_rget, 1'b0);
        chk("rst_first", m_first, 1'b0);
        chk("rst_last", m_last, 1'b0);
        @(negedge rclk);

        // Full burst of 16 then a timed-out burst of 4
        m_ready = 1'b1;
        for (int i = 1; i <= 20; i++) fq.push_back(W'(i));
        drain(400);
        chk("full_len", dlog.size(), 22);
        if (dlog.size() == 22) begin
            chk("full_hdr", dlog[0], {1'b1, 1'b0, 8'h10});
            chk("full_d1", dlog[1], {1'b0, 1'b0, 8'h01});
            chk("full_end", dlog[16], {1'b0, 1'b1, 8'h10});
            chk("b2_hdr", dlog[17], {1'b1, 1'b0, 8'h04});
            chk("b2_d1", dlog[18], {1'b0, 1'b0, 8'h11});
            chk("b2_end", dlog[21], {1'b0, 1'b1, 8'h14});
        end

        // Timeout: header appears 64 no-take cycles after the 3rd take
        dlog.delete();
        hdr_cyc = -1;
        for (int i = 0; i < 3; i++) fq.push_back(8'hA1 + W'(i));
        drain(200);
        chk("to_gap", hdr_cyc - last_take, 65);
        chk("to_len", dlog.size(), 4);
        if (dlog.size() == 4) begin
            chk("to_hdr", dlog[0], {1'b1, 1'b0, 8'h03});
            chk("to_end", dlog[3], {1'b0, 1'b1, 8'hA3});
        end

        // Flush together with the 2nd take
        dlog.delete();
        fq.push_back(8'h5A);
        fq.push_back(8'h5B);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(50);
        chk("fl_len", dlog.size(), 3);
        if (dlog.size() == 3) begin
            chk("fl_hdr", dlog[0], {1'b1, 1'b0, 8'h02});
            chk("fl_end", dlog[2], {1'b0, 1'b1, 8'h5B});
        end

        // Flush while idle does nothing
        dlog.delete();
        flush = 1'b1;
        repeat (3) step();
        flush = 1'b0;
        step();
        chk("fl_idle_out", dlog.size(), 0);
        chk("fl_idle_busy", busy, 1'b0);

        // Reset after 2 of 5 data words, then a fresh burst of 3
        for (int i = 0; i < 5; i++) fq.push_back(8'hC0 + W'(i));
        for (int n = 0; n < 20 && col.size() < 5; n++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int n = 0; n < 20 && dlog.size() < 3; n++) step();
        chk("mr_progress", dlog.size(), 3);
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        #1;
        chk("mr_valid", m_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        @(negedge rclk);
        dlog.delete();
        for (int i = 0; i < 3; i++) fq.push_back(8'hE0 + W'(i));
        drain(200);
        chk("mr_len", dlog.size(), 4);
        if (dlog.size() == 4)
            chk("mr_hdr", dlog[0], {1'b1, 1'b0, 8'h03});

        // Random backpressure, FIFO gaps and flushes
        dlog.delete();
        for (int i = 0; i < 300; i++) fq.push_back(W'($urandom));
        for (int n = 0; n < 20000 && !model_idle(); n++) begin
            m_ready = 1'($urandom_range(0, 1));
            gate = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        gate = 1'b0;
        flush = 1'b0;
        m_ready = 1'b1;
        drain(200);
        ndata = 0;
        foreach (dlog[i]) if (!dlog[i].f) ndata++;
        chk("rnd_words", ndata, 300);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
